// File: rtl/ucie_ctl_adapter_pkg.sv
// Shared types for the adapter-side RDI transmit path.
// State encoding and small arithmetic helpers.
package ucie_ctl_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10
    } rdi_tx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, zero when empty.
// Full/empty derive from the occupancy count; pointers wrap naturally.
module ucie_ctl_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    // Flush dominates; a pop or push in the same cycle is discarded.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
            if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ucie_ctl_adapter_rdi_tx.sv
// Adapter-side RDI transmit stage: buffers core flits and hands them to
// the PHY over lp_valid/pl_trdy, draining (with timeout) on link disable.
module ucie_ctl_adapter_rdi_tx
    import ucie_ctl_adapter_pkg::*;
#(
    parameter int NBYTES        = 8,
    parameter int DEPTH         = 4,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic                     i_tx_valid,
    input  logic [NBYTES*8-1:0]      i_tx_data,
    output logic                     o_tx_ready,
    input  logic                     i_rdi_pl_trdy,
    output logic                     o_rdi_lp_irdy,
    output logic                     o_rdi_lp_valid,
    output logic [NBYTES*8-1:0]      o_rdi_lp_data,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic [15:0]              o_sent_cnt,
    output logic                     o_drop_err
);

    localparam int W  = NBYTES * 8;
    localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [TW-1:0] TLAST = TW'(DRAIN_TIMEOUT - 1);

    rdi_tx_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   sent_q, sent_d;
    logic          drop_q, drop_d;

    logic          full, empty, push, pop, timeout;
    logic [W-1:0]  head;

    ucie_ctl_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (i_flush | timeout),
        .data_i  (i_tx_data),
        .head_o  (head),
        .count_o (o_fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign push    = i_tx_valid & o_tx_ready;
    assign pop     = o_rdi_lp_valid & i_rdi_pl_trdy;
    assign timeout = (state_q == DRAIN) & ~empty & ~i_flush
                   & (timer_q == TLAST) & ~pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            sent_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!i_enable) state_d = empty ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (i_flush || empty || timeout) state_d = IDLE;
                else if (i_enable)               state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timer counts consecutive DRAIN cycles without a pop.
    always_comb begin
        timer_d = '0;
        if (state_q == DRAIN && state_d == DRAIN && !pop)
            timer_d = timer_q + TW'(1);
        sent_d = (pop && !i_flush) ? sat_inc16(sent_q) : sent_q;
        drop_d = drop_q | timeout;
    end

    always_comb begin
        o_rdi_lp_irdy = 1'b0;
        o_tx_ready    = 1'b0;
        unique case (state_q)
            IDLE:    o_rdi_lp_irdy = 1'b0;
            ACTIVE: begin
                o_rdi_lp_irdy = 1'b1;
                o_tx_ready    = ~full & ~i_flush;
            end
            DRAIN:   o_rdi_lp_irdy = 1'b1;
            default: o_rdi_lp_irdy = 1'b0;
        endcase
        o_rdi_lp_valid = o_rdi_lp_irdy & ~empty;
        o_rdi_lp_data  = head;
        o_sent_cnt     = sent_q;
        o_drop_err     = drop_q;
    end

endmodule
